fir_l3_stream_ctrl: RTL
=======================

Name: fir_l3_stream_ctrl

Overview:
Stream controller for the 3-parallel reduced-complexity FIR datapath.
- Input side: collects a serial sample stream (valid/ready) into 3-sample blocks and issues each block to the parallel filter with a clock enable.
- Tracking: follows blocks through the filter latency and drops flush/padding results.
- Output side: buffers filter output blocks in a small FIFO and re-serializes them to a valid/ready output stream.
- Placement: between the serial front end and the enable-gated L=3 filter instance.

Parameters:
DATA_IN_WIDTH, 16, input sample width (two's complement)
DATA_OUT_WIDTH, 64, filter output sample width
LATENCY, 1, filter latency in ce pulses (range 1..8)
OUT_DEPTH, 4, output FIFO depth in 3-sample blocks (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
s_data  in  DATA_IN_WIDTH  serial input sample
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&s_ready
flush  in  1  pulse: pad the partial block, then drain the pipeline
filt_ce  out  1  filter advances one block when high
filt_x1, filt_x2, filt_x3  out  DATA_IN_WIDTH each  block to filter (x1 = oldest sample)
filt_y1, filt_y2, filt_y3  in  DATA_OUT_WIDTH each  filter outputs
m_data  out  DATA_OUT_WIDTH  serial output sample
m_valid  out  1  output valid
m_ready  in  1  output accepted when m_valid&m_ready
m_last  out  1  marks the last sample of a flushed stream
busy  out  1  high in any state other than FILL with an empty pipe and empty FIFO

Behaviour:
- Reset (async, active-high) clears everything:
  - all outputs 0, s_ready=0 while reset is held;
  - FSM=FILL, fill count 0, tag pipe 0, FIFO empty, serializer index 0.
  - Reset mid-operation discards all in-flight data. No output is emitted after reset until new input arrives.
- Fill counter (0..2):
  - Accepted sample goes to slot[cnt]; cnt increments.
  - On the third sample, the block is complete and cnt returns to 0.
- space:
  - Definition: FIFO count + tags in pipe < OUT_DEPTH, or a FIFO pop occurs in the same cycle.
  - s_ready = (state==FILL) & ~(block complete pending) & space.
- Issue: in the cycle after a block completes (state ISSUE):
  - filt_ce=1 and filt_x1..3 = slot0..2, held registered;
  - tag=1 enters the tag pipe;
  - latency: 1 cycle from the third accept to filt_ce.
- Tag pipe: LATENCY bits, shifts only on filt_ce. When filt_ce=1 and the tail tag=1, filt_y1..3 are written as one FIFO entry in that cycle.
- FSM states:
  - FILL → ISSUE on block complete.
  - ISSUE → FILL.
  - FILL → PAD when flush=1 and cnt>0.
  - FILL → DRAIN when flush=1 and cnt==0.
  - PAD: zero-fill the remaining slots, issue as a real block (tag=1, last-pad marker kept), then → DRAIN.
  - DRAIN: filt_ce=1 with zero blocks and tag=0, LATENCY times, gated by space.
  - DRAIN → FILL after LATENCY zero blocks.
  - flush while in ISSUE/PAD/DRAIN: ignored.
  - flush while the pipe is empty and cnt==0: DRAIN still runs (harmless); no m_last is generated.
- m_last: asserted on the third sample of the FIFO entry that was the final real block before a DRAIN. Padding samples are emitted (their values are the filter response to zero input).
- Serializer:
  - m_valid = FIFO not empty; m_data = head.y[idx].
  - On accept, idx increments 0→1→2; on idx 2, pop and idx=0.
  - m_data and m_valid are held stable while m_ready=0.
- Capture while the FIFO is full is impossible by the space rule; verify with an assertion.
- Simultaneous FIFO push and pop in the same cycle is allowed; count stays unchanged.
- Width rules:
  - No arithmetic on data; pass-through only.
  - Zero padding is all-zero DATA_IN_WIDTH.
  - DRAIN zero blocks present 0 on filt_x1..3.

Test Plan:
All tests use LATENCY=2, OUT_DEPTH=4, and an identity stub filter: a 2-stage ce-gated delay with y_i = sign-extended x_i.
- Streaming: send 1..9 with s_valid held high and m_ready=1.
  - filt_ce pulses 3 times, 1 cycle after samples 3, 6 and 9.
  - The block containing 1,2,3 reaches the stub's output after 2 ce pulses, i.e. at the ce for block 7–9, and is captured then.
  - Without further input, blocks 4–6 and 7–9 stay in the pipe.
  - m_data emits 1,2,3 in order; m_last is never asserted.
- Flush/partial: send 1..7, then pulse flush.
  - PAD issues block {7,0,0}; DRAIN issues 2 zero blocks.
  - Output is 1..7, 0, 0, with m_last on the final 0; busy falls afterwards.
- Backpressure: m_ready=0 while streaming 30 samples.
  - s_ready deasserts once FIFO count + pipe tags reaches 4.
  - Nothing is lost. After m_ready=1, all samples emerge in order.
- Stall hold: m_ready=0 with m_valid=1 → m_data stable for 5 cycles.
- Reset mid-block: reset asserted after 2 samples.
  - All outputs 0 immediately (async).
  - After release, sending 10,11,12 then flush → output 10,11,12 with m_last on 12.
- Input gaps: random s_valid gaps. Output sequence equals the input sequence, and filt_ce pulses exactly once per 3 accepted samples.

Source files
------------

// File: rtl/fir_l3_stream_ctrl.sv
// Packs a serial sample stream into 3-sample blocks for the L=3 FIR, tracks them through the filter and re-serializes results.
// Issue 1 cycle after the third accept; s_ready drops when FIFO entries plus in-flight blocks would exceed OUT_DEPTH.
module fir_l3_stream_ctrl #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 64,
  parameter int LATENCY        = 1,
  parameter int OUT_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_IN_WIDTH-1:0]  s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      flush,
  output logic                      filt_ce,
  output logic [DATA_IN_WIDTH-1:0]  filt_x1,
  output logic [DATA_IN_WIDTH-1:0]  filt_x2,
  output logic [DATA_IN_WIDTH-1:0]  filt_x3,
  input  logic [DATA_OUT_WIDTH-1:0] filt_y1,
  input  logic [DATA_OUT_WIDTH-1:0] filt_y2,
  input  logic [DATA_OUT_WIDTH-1:0] filt_y3,
  output logic [DATA_OUT_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      busy
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 4;
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {FILL, ISSUE, PAD, DRAIN} state_t;

  typedef struct packed {
    logic                           last;
    logic [2:0][DATA_OUT_WIDTH-1:0] y;
  } ent_t;

  state_t                          state_q, state_d;
  logic [1:0]                      cnt_q, cnt_d;
  logic [2:0][DATA_IN_WIDTH-1:0]   slot_q, slot_d;
  logic [LATENCY-1:0]              tag_q, tag_d, last_q, last_d;
  logic [DW-1:0]                   dcnt_q, dcnt_d;
  ent_t                            mem_q [OUT_DEPTH];
  ent_t                            mem_d [OUT_DEPTH];
  logic [AW-1:0]                   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]                   fcnt_q, fcnt_d;
  logic [1:0]                      idx_q, idx_d;
  logic [OW-1:0]                   occ;
  logic                            space, accept, push, pop, full_blk, tag_in, last_in;

  // Occupancy counts blocks already buffered plus blocks still inside the filter.
  always_comb begin
    occ = OW'(fcnt_q);
    for (int i = 0; i < LATENCY; i++) occ = occ + OW'(tag_q[i]);
  end

  assign pop     = m_valid & m_ready & (idx_q == 2'd2);
  assign space   = (occ < OW'(OUT_DEPTH)) | pop;
  assign s_ready = ~reset & (state_q == FILL) & space;
  assign accept  = s_valid & s_ready;
  assign m_valid = (fcnt_q != '0);
  assign m_data  = mem_q[rd_q].y[idx_q];
  assign m_last  = m_valid & mem_q[rd_q].last & (idx_q == 2'd2);
  assign busy    = (state_q != FILL) | (tag_q != '0) | m_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    tag_d    = tag_q;
    last_d   = last_q;
    dcnt_d   = dcnt_q;
    filt_ce  = 1'b0;
    filt_x1  = '0;
    filt_x2  = '0;
    filt_x3  = '0;
    tag_in   = 1'b0;
    last_in  = 1'b0;
    full_blk = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          slot_d[cnt_q] = s_data;
          full_blk      = (cnt_q == 2'd2);
          cnt_d         = full_blk ? 2'd0 : cnt_q + 2'd1;
          if (full_blk) state_d = ISSUE;
        end
        if (flush) begin
          if (cnt_d != 2'd0 || full_blk) begin
            for (int i = 0; i < 3; i++)
              if (cnt_d != 2'd0 && 2'(i) >= cnt_d) slot_d[i] = '0;
            cnt_d   = 2'd0;
            state_d = PAD;
          end else begin
            // Youngest real block is still in the pipe: it becomes the end of stream.
            last_d[0] = tag_q[0];
            state_d   = DRAIN;
          end
        end
      end
      ISSUE: begin
        filt_ce = 1'b1;
        filt_x1 = slot_q[0];
        filt_x2 = slot_q[1];
        filt_x3 = slot_q[2];
        tag_in  = 1'b1;
        state_d = FILL;
      end
      PAD: begin
        if (space) begin
          filt_ce = 1'b1;
          filt_x1 = slot_q[0];
          filt_x2 = slot_q[1];
          filt_x3 = slot_q[2];
          tag_in  = 1'b1;
          last_in = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (space) begin
          filt_ce = 1'b1;
          if (dcnt_q == DW'(LATENCY - 1)) begin
            dcnt_d  = '0;
            state_d = FILL;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
    push = filt_ce & tag_q[LATENCY-1];
    if (filt_ce) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_d[i]  = tag_q[i-1];
        last_d[i] = last_q[i-1];
      end
      tag_d[0]  = tag_in;
      last_d[0] = last_in;
    end
  end

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    idx_d  = idx_q;
    if (push) begin
      mem_d[wr_q].last = last_q[LATENCY-1];
      mem_d[wr_q].y    = {filt_y3, filt_y2, filt_y1};
      wr_d             = wr_q + AW'(1);
    end
    if (m_valid & m_ready) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    if (pop) rd_d = rd_q + AW'(1);
    fcnt_d = fcnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      slot_q  <= '0;
      tag_q   <= '0;
      last_q  <= '0;
      dcnt_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
      idx_q   <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
      dcnt_q  <= dcnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    push |-> ((fcnt_q < CW'(OUT_DEPTH)) || pop));

endmodule
